// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the streaming Gray-to-binary decoder.
// Helpers work on GRAY_MAX_W-bit words; narrower words are zero-extended, which leaves the results unchanged.
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef logic [GRAY_MAX_W-1:0] gword_t;

   // S1 pipe entry: the accepted Gray word and its step-check verdict.
   typedef struct packed {
      gword_t gray;
      logic   err;
   } s1_t;

   function automatic gword_t gray2bin(input gword_t g);
      gword_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic gword_t bin2gray(input gword_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic int unsigned popcount(input gword_t v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
// No state, zero latency, no flow control.
module gray_to_binary #(
   parameter int VEC_W = 4
) (
   input  logic [VEC_W-1:0] gray,
   output logic [VEC_W-1:0] bin
);

   for (genvar i = 0; i < VEC_W; i++) begin : g_bit
      assign bin[i] = ^gray[VEC_W-1:i];
   end

endmodule

// File: rtl/gray_to_binary_stream.sv
// Streaming Gray-to-binary decoder with single-bit-step checking, 2-stage valid/ready pipe.
// Latency 2 cycles, 1 word/cycle; a stalled output backs up both stages before ready_o drops.
module gray_to_binary_stream
   import gray_pkg::*;
#(
   parameter int VEC_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic [VEC_W-1:0] gray_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [VEC_W-1:0] bin_o,
   output logic             step_err_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             s1_vld;
   logic             s2_vld;
   logic             s1_adv;
   logic             s2_adv;
   logic             in_acc;
   logic             out_hs;
   logic             step_err;
   s1_t              s1_q;
   logic [VEC_W-1:0] dec_bin;
   logic [VEC_W-1:0] prev_gray;
   logic             prev_vld;
   logic             unused_bits;

   assign s2_adv  = !s2_vld || ready_i;
   assign s1_adv  = !s1_vld || s2_adv;
   assign ready_o = s1_adv;
   assign in_acc  = valid_i && s1_adv;
   assign out_hs  = s2_vld && ready_i;
   assign valid_o = s2_vld;

   // A clear in the accept cycle makes this word the first of a new sequence.
   assign step_err = prev_vld && !clr_i &&
                     (popcount(gword_t'(gray_i ^ prev_gray)) != 32'd1);

   // Upper S1 bits beyond VEC_W are always zero and intentionally ignored.
   assign unused_bits = ^s1_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_q   <= '0;
      end else if (s1_adv) begin
         s1_vld <= valid_i;
         if (valid_i) begin
            s1_q.gray <= gword_t'(gray_i);
            s1_q.err  <= step_err;
         end
      end
   end

   gray_to_binary #(
      .VEC_W (VEC_W)
   ) u_dec (
      .gray (s1_q.gray[VEC_W-1:0]),
      .bin  (dec_bin)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_vld     <= 1'b0;
         bin_o      <= '0;
         step_err_o <= 1'b0;
      end else if (s2_adv) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            bin_o      <= dec_bin;
            step_err_o <= s1_q.err;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_gray <= '0;
         prev_vld  <= 1'b0;
      end else if (in_acc) begin
         prev_gray <= gray_i;
         prev_vld  <= 1'b1;
      end else if (clr_i) begin
         prev_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_o <= '0;
      end else if (clr_i) begin
         err_cnt_o <= '0;
      end else if (out_hs && step_err_o && (err_cnt_o != CNT_MAX)) begin
         err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gray_to_binary_stream.sv
// Directed bench for gray_to_binary_stream (VEC_W=4, CNT_W=2): cycle table plus clear/reset corner sequences.
module tb_gray_to_binary_stream;

   logic       clk;
   logic       reset;
   logic       clr_i;
   logic [3:0] gray_i;
   logic       valid_i;
   logic       ready_o;
   logic [3:0] bin_o;
   logic       step_err_o;
   logic       valid_o;
   logic       ready_i;
   logic [1:0] err_cnt_o;

   int n_checks = 0;
   int n_fails  = 0;

   gray_to_binary_stream #(
      .VEC_W (4),
      .CNT_W (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (clr_i),
      .gray_i     (gray_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .bin_o      (bin_o),
      .step_err_o (step_err_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .err_cnt_o  (err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row per cycle: inputs driven after the falling edge, outputs expected at that moment.
   typedef struct packed {
      logic       clr;
      logic       vld;
      logic [3:0] gray;
      logic       rdy;
      logic       e_vld;
      logic [3:0] e_bin;
      logic       e_err;
      logic [1:0] e_cnt;
      logic       e_rdy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(input logic c, input logic v, input logic [3:0] g, input logic r,
                                input logic ev, input logic [3:0] eb, input logic ee,
                                input logic [1:0] ec, input logic er);
      vec_t x;
      x = '{c, v, g, r, ev, eb, ee, ec, er};
      return x;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic v, input logic [3:0] g, input logic r);
      clr_i   = c;
      valid_i = v;
      gray_i  = g;
      ready_i = r;
   endtask

   initial begin
      // basic stream
      tbl.push_back(row(0, 1, 4'b0000, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0001, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0011, 1, 1,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0010, 1, 1,  1, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  2, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  3, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 0,  0, 0, 0, 1));
      // backpressure: two words absorbed, third held
      tbl.push_back(row(0, 1, 4'b0110, 0, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0111, 0, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0101, 0, 1,  4, 0, 0, 0));
      tbl.push_back(row(0, 1, 4'b0101, 0, 1,  4, 0, 0, 0));
      tbl.push_back(row(0, 1, 4'b0101, 1, 1,  4, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  5, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  6, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 0,  0, 0, 0, 1));
      // step error and repeated word
      tbl.push_back(row(1, 0, 4'b0000, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0000, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0011, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0011, 1, 1,  0, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  2, 1, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  2, 1, 1, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 0,  0, 0, 2, 1));
      // wrap 1000 -> 0000, then five illegal steps saturate the counter
      tbl.push_back(row(1, 0, 4'b0000, 1, 0,  0, 0, 2, 1));
      tbl.push_back(row(0, 1, 4'b1000, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0000, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0011, 1, 1, 15, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0000, 1, 1,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b0011, 1, 1,  2, 1, 0, 1));
      tbl.push_back(row(0, 1, 4'b0000, 1, 1,  0, 1, 1, 1));
      tbl.push_back(row(0, 1, 4'b0011, 1, 1,  2, 1, 2, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  0, 1, 3, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1,  2, 1, 3, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 0,  0, 0, 3, 1));
      // clear together with the accept of 1111 after 0000
      tbl.push_back(row(1, 0, 4'b0000, 1, 0,  0, 0, 3, 1));
      tbl.push_back(row(0, 1, 4'b0000, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(1, 1, 4'b1111, 1, 0,  0, 0, 0, 1));
      tbl.push_back(row(0, 1, 4'b1110, 1, 1,  0, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1, 10, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 1, 11, 0, 0, 1));
      tbl.push_back(row(0, 0, 4'b0000, 1, 0,  0, 0, 0, 1));

      reset = 1'b1;
      drive(0, 0, 4'b0000, 1);
      @(negedge clk);
      #1;
      chk("reset valid_o", int'(valid_o), 0);
      chk("reset err_cnt_o", int'(err_cnt_o), 0);
      chk("reset ready_o", int'(ready_o), 1);
      reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].clr, tbl[i].vld, tbl[i].gray, tbl[i].rdy);
         #1;
         chk($sformatf("row%0d valid_o", i), int'(valid_o), int'(tbl[i].e_vld));
         chk($sformatf("row%0d ready_o", i), int'(ready_o), int'(tbl[i].e_rdy));
         chk($sformatf("row%0d err_cnt_o", i), int'(err_cnt_o), int'(tbl[i].e_cnt));
         if (tbl[i].e_vld) begin
            chk($sformatf("row%0d bin_o", i), int'(bin_o), int'(tbl[i].e_bin));
            chk($sformatf("row%0d step_err_o", i), int'(step_err_o), int'(tbl[i].e_err));
         end
      end

      // clear coinciding with an erroneous output handshake: counter ends at 0
      @(negedge clk); drive(0, 1, 4'b1110, 1);
      @(negedge clk); drive(0, 0, 4'b0000, 1);
      @(negedge clk); drive(1, 0, 4'b0000, 1);
      #1;
      chk("clrhs valid_o", int'(valid_o), 1);
      chk("clrhs bin_o", int'(bin_o), 11);
      chk("clrhs step_err_o", int'(step_err_o), 1);
      @(negedge clk); drive(0, 0, 4'b0000, 1);
      #1;
      chk("clrhs err_cnt_o", int'(err_cnt_o), 0);
      chk("clrhs drained", int'(valid_o), 0);

      // reset with two words in flight
      @(negedge clk); drive(0, 1, 4'b0000, 1);
      @(negedge clk); drive(0, 1, 4'b0011, 1);
      @(negedge clk); drive(0, 0, 4'b0000, 1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre-reset err_cnt_o", int'(err_cnt_o), 1);
      drive(0, 1, 4'b0110, 0);
      @(negedge clk); drive(0, 1, 4'b0111, 0);
      @(negedge clk); drive(0, 1, 4'b0101, 0);
      #1;
      chk("in-flight ready_o", int'(ready_o), 0);
      chk("in-flight valid_o", int'(valid_o), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset valid_o", int'(valid_o), 0);
      chk("async reset err_cnt_o", int'(err_cnt_o), 0);
      chk("async reset bin_o", int'(bin_o), 0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1, 4'b0101, 1);
      #1;
      chk("post-reset ready_o", int'(ready_o), 1);
      chk("post-reset valid_o", int'(valid_o), 0);
      @(negedge clk); drive(0, 0, 4'b0000, 1);
      #1;
      chk("post-reset stale data", int'(valid_o), 0);
      @(negedge clk);
      #1;
      chk("post-reset first valid_o", int'(valid_o), 1);
      chk("post-reset first bin_o", int'(bin_o), 6);
      chk("post-reset first step_err_o", int'(step_err_o), 0);
      chk("post-reset err_cnt_o", int'(err_cnt_o), 0);
      @(negedge clk);
      #1;
      chk("post-reset single word", int'(valid_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
